// File: rtl/fir_mult_sched.sv
// fir_mult_sched: 5-tap FIR controller sharing one external mult16 across five MAC cycles
module fir_mult_sched #(
  parameter logic [15:0] C0 = 16'd32,
  parameter logic [15:0] C1 = 16'd64,
  parameter logic [15:0] C2 = 16'd256,
  parameter logic [15:0] C3 = 16'd64,
  parameter logic [15:0] C4 = 16'd32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] din,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] dout,
  output logic [15:0] mult_a,
  output logic [15:0] mult_b,
  input  logic [31:0] mult_p,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;
  state_t      r_state;
  logic [2:0]  r_tap;
  logic [15:0] r_x [5];
  logic [31:0] r_acc;
  logic [31:0] r_dout;
  logic        w_accept;
  logic [15:0] w_x;
  logic [15:0] w_c;
  // sample/coefficient pair for the current tap; tap never exceeds 4 while in MAC
  always_comb begin
    w_x = r_tap == 3'd0 ? r_x[0] : r_tap == 3'd1 ? r_x[1] : r_tap == 3'd2 ? r_x[2] : r_tap == 3'd3 ? r_x[3] : r_x[4];
    w_c = r_tap == 3'd0 ? C0 : r_tap == 3'd1 ? C1 : r_tap == 3'd2 ? C2 : r_tap == 3'd3 ? C3 : C4;
  end
  assign in_ready  = !rst && !flush && (r_state == IDLE || (r_state == DONE && out_ready));
  assign w_accept  = in_valid && in_ready;
  assign busy      = r_state == MAC;
  assign out_valid = r_state == DONE;
  assign mult_a    = busy ? w_x : '0;
  assign mult_b    = busy ? w_c : '0;
  assign dout      = r_dout;
  // FSM, delay line and accumulator; flush outranks both accept and MAC updates
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_tap   <= '0;
      r_acc   <= '0;
      r_dout  <= '0;
      for (int i = 0; i < 5; i++) r_x[i] <= '0;
    end else if (flush) begin
      r_state <= IDLE;
      r_tap   <= '0;
      r_acc   <= '0;
      r_dout  <= '0;
      for (int i = 0; i < 5; i++) r_x[i] <= '0;
    end else if (w_accept) begin
      r_x[0]  <= din;
      for (int i = 1; i < 5; i++) r_x[i] <= r_x[i-1];
      r_acc   <= '0;
      r_tap   <= '0;
      r_state <= MAC;
    end else if (r_state == MAC) begin
      r_acc <= r_acc + mult_p;
      r_tap <= r_tap == 3'd4 ? 3'd0 : r_tap + 3'd1;
      if (r_tap == 3'd4) begin
        r_dout  <= r_acc + mult_p;
        r_state <= DONE;
      end
    end else if (r_state == DONE && out_ready) begin
      r_state <= IDLE;
    end
  end
endmodule

// File: tb/tb_fir_mult_sched.sv
// tb_fir_mult_sched: randomized and directed checks of fir_mult_sched against a windowed-sum reference
module tb_fir_mult_sched;
  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] din;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] dout;
  logic [15:0] mult_a;
  logic [15:0] mult_b;
  logic [31:0] mult_p;
  logic        busy;

  localparam int C [5] = '{32, 64, 256, 64, 32};

  int          n_chk = 0;
  int          n_fail = 0;
  int          n_in = 0;
  int          n_out = 0;
  int          m_left = 0;
  bit          m_pend = 0;
  logic [31:0] m_dout = 0;
  logic [31:0] m_y = 0;
  logic [15:0] win [5];
  logic [31:0] outs [$];

  fir_mult_sched dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .din(din), .out_valid(out_valid), .out_ready(out_ready), .dout(dout),
    .mult_a(mult_a), .mult_b(mult_b), .mult_p(mult_p), .busy(busy)
  );

  assign mult_p = (32'(mult_a) * 32'(mult_b)) >> 8;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 5; i++) win[i] = '0;
    m_left = 0;
    m_pend = 0;
    m_dout = '0;
  endtask

  task automatic step(input logic v, input logic [15:0] d, input logic ordy, input logic fl, output bit a);
    bit exp_ir;
    int y;
    in_valid = v;
    din = d;
    out_ready = ordy;
    flush = fl;
    #1;
    exp_ir = !fl && m_left == 0 && (!m_pend || ordy);
    chk("in_ready", 32'(in_ready), 32'(exp_ir));
    chk("busy", 32'(busy), 32'(m_left > 0));
    chk("out_valid", 32'(out_valid), 32'(m_pend));
    chk("dout", dout, m_dout);
    if (m_left > 0) begin
      chk("mult_a", 32'(mult_a), 32'(win[5-m_left]));
      chk("mult_b", 32'(mult_b), 32'(C[5-m_left]));
    end else begin
      chk("mult_a_idle", 32'(mult_a), 0);
      chk("mult_b_idle", 32'(mult_b), 0);
    end
    a = v && exp_ir;
    if (out_valid && ordy && !fl) begin
      outs.push_back(dout);
      n_out++;
    end
    if (fl) model_clear();
    else if (a) begin
      for (int i = 4; i > 0; i--) win[i] = win[i-1];
      win[0] = d;
      y = 0;
      for (int k = 0; k < 5; k++) y += (C[k] * int'(win[k])) / 256;
      m_y = 32'(y);
      m_left = 5;
      m_pend = 0;
      n_in++;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_pend = 1;
        m_dout = m_y;
      end
    end else if (m_pend && ordy) m_pend = 0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [15:0] d);
    bit a = 0;
    for (int t = 0; t < 20 && !a; t++) step(1'b1, d, 1'b1, 1'b0, a);
    if (!a) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    bit a;
    for (int t = 0; t < 10; t++) step(1'b0, 16'd0, 1'b1, 1'b0, a);
  endtask

  initial begin
    bit a;
    int imp [6] = '{32, 64, 256, 64, 32, 0};
    rst = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    din = '0;
    model_clear();
    #3;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_dout", dout, 0);
    @(negedge clk);
    rst = 1'b0;

    outs.delete();
    send(16'd256);
    for (int i = 0; i < 5; i++) send(16'd0);
    drain();
    chk("impulse_count", 32'(outs.size()), 6);
    for (int i = 0; i < 6 && i < outs.size(); i++) chk("impulse_val", outs[i], 32'(imp[i]));

    outs.delete();
    for (int i = 0; i < 5; i++) send(16'hFFFF);
    drain();
    chk("max_count", 32'(outs.size()), 5);
    if (outs.size() == 5) chk("max_val", outs[4], 32'd114683);

    outs.delete();
    send(16'd100);
    for (int t = 0; t < 10 && !m_pend; t++) step(1'b1, 16'd200, 1'b0, 1'b0, a);
    chk("bp_reached_done", 32'(out_valid), 1);
    for (int t = 0; t < 10; t++) step(1'b1, 16'd200, 1'b0, 1'b0, a);
    step(1'b1, 16'd200, 1'b1, 1'b0, a);
    chk("bp_accept_on_ready", 32'(a), 1);
    drain();
    chk("bp_count", 32'(outs.size()), 2);
    if (outs.size() == 2) begin
      chk("bp_first", outs[0], 32'd106504);
      chk("bp_second", outs[1], 32'd90159);
    end

    outs.delete();
    send(16'd300);
    step(1'b0, 16'd0, 1'b1, 1'b0, a);
    step(1'b0, 16'd0, 1'b1, 1'b0, a);
    step(1'b0, 16'd0, 1'b1, 1'b1, a);
    send(16'd256);
    drain();
    chk("flush_count", 32'(outs.size()), 1);
    if (outs.size() == 1) chk("flush_impulse", outs[0], 32'd32);

    outs.delete();
    send(16'd1000);
    step(1'b0, 16'd0, 1'b1, 1'b0, a);
    step(1'b0, 16'd0, 1'b1, 1'b0, a);
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_mult_a", 32'(mult_a), 0);
    chk("arst_mult_b", 32'(mult_b), 0);
    chk("arst_in_ready", 32'(in_ready), 0);
    chk("arst_dout", dout, 0);
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    send(16'd256);
    drain();
    chk("arst_count", 32'(outs.size()), 1);
    if (outs.size() == 1) chk("arst_impulse", outs[0], 32'd32);

    n_in = 0;
    n_out = 0;
    for (int c = 0; c < 5000 && n_in < 200; c++)
      step($urandom_range(0, 3) != 0, 16'($urandom_range(0, 65535)), $urandom_range(0, 3) != 0, 1'b0, a);
    drain();
    chk("rand_in_count", 32'(n_in), 200);
    chk("rand_in_eq_out", 32'(n_out), 32'(n_in));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
